// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file with scoreboard:
//   - rf_state_t : flash-clear sequencer states (IDLE, CLEAR)
//   - sel_width  : select width for a register count, never less than 1 bit
//   - DEF_*      : default data width and register count
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  // $clog2(2) is 1, but $clog2(1) would be 0; keep selects at least 1 bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_word.sv
// -----------------------------------------------------------------------------
// rf_word
// One register of the file.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears q
//   we   : load d on the next edge
//   clr  : synchronous clear, takes priority over we
//   d    : write data
//   q    : stored value
// -----------------------------------------------------------------------------
module rf_word
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rf_sb_param.sv
// -----------------------------------------------------------------------------
// rf_sb_param
// Decode-stage register file: NUM_RD combinational read ports, one writeback
// port, per-register pending-write scoreboard, optional write-to-read bypass,
// optional hardwired-zero register 0 and a flash-clear sequencer.
//   clk/rst  : rising-edge clock, asynchronous active-low reset
//   rd_sel   : packed read selects, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  : packed read data,    port i at [i*DATA_W +: DATA_W]
//   rd_busy  : scoreboard pending flag per read port
//   wr_*     : writeback port (clears the target's busy bit)
//   iss_*    : issue port (sets the target's busy bit)
//   clr_req  : start flash clear of all registers and busy bits
//   ready    : 1 when idle and accepting writes/issues
//   err      : sticky error (bad select or WAW hazard leak)
// -----------------------------------------------------------------------------
module rf_sb_param
  import rf_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = sel_width(NUM_REGS),
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_sel,
  input  logic                     clr_req,
  output logic                     ready,
  output logic                     err
);

  // One extra bit so the count itself fits when NUM_REGS is a power of two.
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  rf_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]  cnt_reg, cnt_next;
  logic               err_reg, err_next;
  logic [NUM_REGS-1:0] busy_reg;
  logic [DATA_W-1:0]  word_q [NUM_REGS];

  logic idle, clearing;
  logic wr_valid, iss_valid, wr_zero, iss_zero;
  logic wr_ok, iss_ok;
  logic [NUM_RD-1:0] rd_bad;

  assign idle     = (state_reg == IDLE);
  assign clearing = (state_reg == CLEAR);
  assign ready    = idle;
  assign err      = err_reg;

  assign wr_valid  = ({1'b0, wr_sel}  < REG_LIMIT);
  assign iss_valid = ({1'b0, iss_sel} < REG_LIMIT);
  assign wr_zero   = (ZERO_REG0 != 0) && (wr_sel  == '0);
  assign iss_zero  = (ZERO_REG0 != 0) && (iss_sel == '0);
  assign wr_ok     = wr_en  && idle && wr_valid  && !wr_zero;
  assign iss_ok    = iss_en && idle && iss_valid && !iss_zero;

  // Register array and scoreboard bits
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
    logic wr_hit, iss_hit, clr_hit;

    assign wr_hit  = wr_ok  && (wr_sel  == IDX);
    assign iss_hit = iss_ok && (iss_sel == IDX);
    assign clr_hit = clearing && (cnt_reg == IDX);

    rf_word #(.DATA_W(DATA_W)) u_word (
      .clk (clk),
      .rst (rst),
      .we  (wr_hit),
      .clr (clr_hit),
      .d   (wr_data),
      .q   (word_q[gi])
    );

    // Issue beats writeback when both target this register in one cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        busy_reg[gi] <= 1'b0;
      end else if (clr_hit) begin
        busy_reg[gi] <= 1'b0;
      end else if (iss_hit) begin
        busy_reg[gi] <= 1'b1;
      end else if (wr_hit) begin
        busy_reg[gi] <= 1'b0;
      end
    end
  end

  // Read ports. wr_ok is never set during CLEAR, so bypass is off there too.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic              sel_ok;
    logic [DATA_W-1:0] data_v;
    logic              busy_v;

    assign sel        = rd_sel[gi*ADDR_W +: ADDR_W];
    assign sel_ok     = ({1'b0, sel} < REG_LIMIT);
    assign rd_bad[gi] = !sel_ok;

    always_comb begin
      data_v = '0;
      busy_v = 1'b0;
      if (sel_ok && !((ZERO_REG0 != 0) && (sel == '0))) begin
        data_v = word_q[sel];
        busy_v = busy_reg[sel];
        if ((BYPASS != 0) && wr_ok && (wr_sel == sel)) begin
          data_v = wr_data;
          busy_v = 1'b0;
        end
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data_v;
    assign rd_busy[gi]                  = busy_v;
  end

  // Dropped (not ready) writes/issues are silent; read selects always count.
  always_comb begin
    err_next = err_reg;
    if ((|rd_bad) ||
        (wr_en  && idle && !wr_valid) ||
        (iss_en && idle && !iss_valid) ||
        (iss_ok && busy_reg[iss_sel] && !(wr_ok && (wr_sel == iss_sel)))) begin
      err_next = 1'b1;
    end
  end

  // Flash-clear sequencer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt_reg == LAST_IDX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_rf_sb_param.sv
// -----------------------------------------------------------------------------
// tb_rf_sb_param
// Directed bench for rf_sb_param. Three instances: default (bypass on),
// bypass off (sharing the same stimulus), and a 6-register / zero-reg0 /
// 3-read-port variant. Expected values are queued as stimulus is driven and
// popped when the corresponding output is sampled.
// -----------------------------------------------------------------------------
module tb_rf_sb_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Shared stimulus for instances A (BYPASS=1) and B (BYPASS=0)
  logic [5:0]  rd_sel;
  logic        wr_en, iss_en, clr_req;
  logic [2:0]  wr_sel, iss_sel;
  logic [15:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        ready_a, ready_b, err_a, err_b;

  // Instance C: NUM_REGS=6, ZERO_REG0=1, NUM_RD=3
  logic [8:0]  rd_sel_c;
  logic        wr_en_c, iss_en_c, clr_req_c;
  logic [2:0]  wr_sel_c, iss_sel_c;
  logic [15:0] wr_data_c;
  logic [47:0] rd_data_c;
  logic [2:0]  rd_busy_c;
  logic        ready_c, err_c;

  rf_sb_param #(.BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .iss_en(iss_en), .iss_sel(iss_sel),
    .clr_req(clr_req), .ready(ready_a), .err(err_a)
  );

  rf_sb_param #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .iss_en(iss_en), .iss_sel(iss_sel),
    .clr_req(clr_req), .ready(ready_b), .err(err_b)
  );

  rf_sb_param #(.NUM_REGS(6), .ZERO_REG0(1), .NUM_RD(3)) u_c (
    .clk(clk), .rst(rst), .rd_sel(rd_sel_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wr_en(wr_en_c), .wr_sel(wr_sel_c), .wr_data(wr_data_c), .iss_en(iss_en_c),
    .iss_sel(iss_sel_c), .clr_req(clr_req_c), .ready(ready_c), .err(err_c)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_v(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
      $display("chk %-16s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rd_sel = '0; wr_en = 0; wr_sel = '0; wr_data = '0; iss_en = 0; iss_sel = '0; clr_req = 0;
    rd_sel_c = '0; wr_en_c = 0; wr_sel_c = '0; wr_data_c = '0; iss_en_c = 0; iss_sel_c = '0;
    clr_req_c = 0;
    #1 rst = 1'b0;
    #1;
    // ---------------- reset state
    expect_v("rst_ready_a", 64'd1); observe(64'(ready_a));
    expect_v("rst_err_a",   64'd0); observe(64'(err_a));
    expect_v("rst_data_a",  64'd0); observe(64'(rd_data_a));
    expect_v("rst_busy_a",  64'd0); observe(64'(rd_busy_a));
    expect_v("rst_ready_c", 64'd1); observe(64'(ready_c));
    @(negedge clk); rst = 1'b1;

    // ---------------- write / read
    @(negedge clk);
    wr_en = 1; wr_sel = 3'd3; wr_data = 16'hBEEF; rd_sel = {3'd5, 3'd3};
    expect_v("wr_byp_a",   64'hBEEF);
    expect_v("wr_nobyp_b", 64'h0000);
    #1; observe(64'(rd_data_a[15:0])); observe(64'(rd_data_b[15:0]));
    @(negedge clk); wr_en = 0;
    expect_v("rd3_a", 64'hBEEF);
    expect_v("rd5_a", 64'h0000);
    expect_v("rd3_b", 64'hBEEF);
    #1; observe(64'(rd_data_a[15:0])); observe(64'(rd_data_a[31:16]));
    observe(64'(rd_data_b[15:0]));

    // ---------------- bypass
    @(negedge clk);
    wr_en = 1; wr_sel = 3'd2; wr_data = 16'h1234; rd_sel = {3'd5, 3'd2};
    expect_v("byp_a",   64'h1234);
    expect_v("nobyp_b", 64'h0000);
    #1; observe(64'(rd_data_a[15:0])); observe(64'(rd_data_b[15:0]));
    @(negedge clk); wr_en = 0;
    expect_v("late_b", 64'h1234);
    #1; observe(64'(rd_data_b[15:0]));

    // ---------------- scoreboard
    @(negedge clk);
    iss_en = 1; iss_sel = 3'd4; rd_sel = {3'd5, 3'd4};
    expect_v("iss_pre_a", 64'd0);
    #1; observe(64'(rd_busy_a));
    @(negedge clk); iss_en = 0;
    expect_v("iss_busy_a", 64'b01);
    expect_v("iss_busy_b", 64'b01);
    #1; observe(64'(rd_busy_a)); observe(64'(rd_busy_b));
    @(negedge clk);
    wr_en = 1; wr_sel = 3'd4; wr_data = 16'h5555;
    expect_v("wb_byp_busy_a", 64'b00);
    expect_v("wb_nobyp_b",    64'b01);
    #1; observe(64'(rd_busy_a)); observe(64'(rd_busy_b));
    @(negedge clk); wr_en = 0;
    expect_v("wb_busy_a", 64'b00);
    expect_v("wb_busy_b", 64'b00);
    expect_v("wb_err_a",  64'd0);
    #1; observe(64'(rd_busy_a)); observe(64'(rd_busy_b)); observe(64'(err_a));

    // ---------------- WAW hazard
    @(negedge clk); iss_en = 1; iss_sel = 3'd4;
    @(negedge clk);
    expect_v("waw_pre_a", 64'd0);
    #1; observe(64'(err_a));
    @(negedge clk); iss_en = 0;
    expect_v("waw_err_a", 64'd1);
    expect_v("waw_err_b", 64'd1);
    #1; observe(64'(err_a)); observe(64'(err_b));
    repeat (3) @(negedge clk);
    expect_v("err_sticky_a", 64'd1);
    #1; observe(64'(err_a));

    // ---------------- flash clear
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wr_en = 1; wr_sel = 3'(k); wr_data = 16'(32'h1100 + k + 1);
    end
    @(negedge clk);
    wr_en = 0; clr_req = 1; rd_sel = {3'd7, 3'd0};
    expect_v("pre_clr_r0", 64'h1101);
    #1; observe(64'(rd_data_a[15:0]));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      clr_req = 0;
      wr_en = 1; wr_sel = 3'd7; wr_data = 16'hDEAD;
      rd_sel = {(c == 0) ? 3'd0 : 3'(c - 1), 3'(c)};
      expect_v("clr_ready_a", 64'd0);
      expect_v("clr_live_a",  64'(32'h1100 + c + 1));
      expect_v("clr_done_a",  (c == 0) ? 64'h1101 : 64'h0);
      #1; observe(64'(ready_a)); observe(64'(rd_data_a[15:0]));
      observe(64'(rd_data_a[31:16]));
    end
    @(negedge clk);
    wr_en = 0; rd_sel = {3'd6, 3'd7};
    expect_v("clr_end_ready_a", 64'd1);
    expect_v("clr_end_ready_b", 64'd1);
    expect_v("clr_end_data_a",  64'd0);
    expect_v("clr_end_err_a",   64'd1);
    #1; observe(64'(ready_a)); observe(64'(ready_b)); observe(64'(rd_data_a));
    observe(64'(err_a));

    // ---------------- reset mid-clear
    @(negedge clk);
    wr_en = 1; wr_sel = 3'd5; wr_data = 16'hAAAA; iss_en = 1; iss_sel = 3'd6;
    @(negedge clk);
    wr_en = 0; iss_en = 0; rd_sel = {3'd6, 3'd5}; clr_req = 1;
    expect_v("pre_rst_data_a", 64'hAAAA);
    expect_v("pre_rst_busy_a", 64'b10);
    #1; observe(64'(rd_data_a[15:0])); observe(64'(rd_busy_a));
    @(negedge clk); clr_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_v("mid_rst_ready_a", 64'd1);
    expect_v("mid_rst_data_a",  64'd0);
    expect_v("mid_rst_busy_a",  64'd0);
    expect_v("mid_rst_err_a",   64'd0);
    #1; observe(64'(ready_a)); observe(64'(rd_data_a)); observe(64'(rd_busy_a));
    observe(64'(err_a));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    wr_en = 1; wr_sel = 3'd5; wr_data = 16'h0F0F;
    expect_v("post_rst_ready_a", 64'd1);
    #1; observe(64'(ready_a));
    @(negedge clk); wr_en = 0;
    expect_v("post_rst_wr_a",    64'h0F0F);
    expect_v("post_rst_ready_b", 64'd1);
    #1; observe(64'(rd_data_a[15:0])); observe(64'(ready_b));

    // ---------------- param sweep (instance C)
    @(negedge clk);
    wr_en_c = 1; wr_sel_c = 3'd0; wr_data_c = 16'hFFFF; iss_en_c = 1; iss_sel_c = 3'd0;
    rd_sel_c = {3'd0, 3'd0, 3'd0};
    expect_v("c_r0_byp", 64'd0);
    #1; observe(64'(rd_data_c[15:0]));
    @(negedge clk);
    wr_en_c = 1; wr_sel_c = 3'd1; wr_data_c = 16'h1111; iss_en_c = 0;
    expect_v("c_r0_zero", 64'd0);
    expect_v("c_r0_busy", 64'd0);
    #1; observe(64'(rd_data_c)); observe(64'(rd_busy_c));
    @(negedge clk); wr_sel_c = 3'd2; wr_data_c = 16'h2222;
    @(negedge clk); wr_sel_c = 3'd5; wr_data_c = 16'h5555;
    @(negedge clk);
    wr_en_c = 0; rd_sel_c = {3'd1, 3'd2, 3'd5};
    expect_v("c_rd3", {16'h0, 16'h1111, 16'h2222, 16'h5555});
    expect_v("c_err_pre", 64'd0);
    #1; observe(64'(rd_data_c)); observe(64'(err_c));
    @(negedge clk);
    wr_en_c = 1; wr_sel_c = 3'd7; wr_data_c = 16'h7777;
    expect_v("c_bad_wr_now", 64'd0);
    #1; observe(64'(err_c));
    @(negedge clk); wr_en_c = 0;
    expect_v("c_bad_wr_err", 64'd1);
    expect_v("c_rd3_keep",   {16'h0, 16'h1111, 16'h2222, 16'h5555});
    #1; observe(64'(err_c)); observe(64'(rd_data_c));
    @(negedge clk); rd_sel_c = {3'd4, 3'd3, 3'd0};
    expect_v("c_rd_untouched", 64'd0);
    #1; observe(64'(rd_data_c));
    @(negedge clk); rd_sel_c = {3'd5, 3'd1, 3'd2};
    expect_v("c_rd3_perm", {16'h0, 16'h5555, 16'h1111, 16'h2222});
    expect_v("c_ready",    64'd1);
    #1; observe(64'(rd_data_c)); observe(64'(ready_c));

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_sb_param.md
Name: rf_sb_param

Overview:
Parametrised successor to the fixed 8x16 two-read/one-write register file. Adds configurable width, depth and read-port count, write-to-read bypass, a hardwired-zero register mode, a per-register scoreboard, and a multi-cycle flash-clear sequencer. Sits in the decode stage of the pipelined core. Read ports feed operand muxes; rd_busy feeds hazard/stall logic; the write port is driven from writeback.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of registers (>=2, need not be a power of 2)
ADDR_W, $clog2(NUM_REGS), select width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
ZERO_REG0, 0, 1 = register 0 reads as 0 and ignores writes and issues

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_sel  in  NUM_RD*ADDR_W  read selects, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  scoreboard pending-write flag for each read port
wr_en  in  1  writeback enable
wr_sel  in  ADDR_W  writeback target
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue: mark iss_sel as pending-write
iss_sel  in  ADDR_W  issue target
clr_req  in  1  start flash clear (single-cycle pulse or level)
ready  out  1  1 = IDLE and accepting writes and issues
err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async): all registers 0, all busy bits 0, FSM=IDLE, clear counter 0, ready=1, err=0. Takes effect immediately, including in the middle of a clear.
- Write: at posedge, if wr_en & ready & sel valid, and not (ZERO_REG0 & wr_sel==0), reg[wr_sel] <= wr_data and busy[wr_sel] <= 0.
- Issue: at posedge, if iss_en & ready & sel valid, and not (ZERO_REG0 & iss_sel==0), busy[iss_sel] <= 1.
- Write and issue to the same register in the same cycle: data is written and busy ends at 1 (issue wins).
- Read, combinational, zero latency: rd_data_i = reg[rd_sel_i].
  - ZERO_REG0 & rd_sel_i==0 -> 0.
  - rd_sel_i >= NUM_REGS -> 0.
  - BYPASS=1 and an accepted write hits rd_sel_i this cycle -> wr_data.
- rd_busy_i = busy[rd_sel_i], forced 0 when BYPASS=1 and an accepted write hits rd_sel_i in the same cycle. 0 for an invalid sel.
- "Sel valid" means sel < NUM_REGS.
- err is sticky (set, never cleared except by rst). It is set at posedge on either:
  - (a) an enabled wr, iss or any rd port with sel >= NUM_REGS, or
  - (b) iss_en accepted to a register already busy with no accepted write to it in that cycle (WAW hazard leak).
- Writes and issues with ready=0 are dropped silently. They do not set err.
- FSM states: IDLE, CLEAR.
  - IDLE: clr_req=1 -> CLEAR, cnt<=0. That same edge's wr/iss are still accepted.
  - CLEAR: each cycle reg[cnt]<=0, busy[cnt]<=0, cnt<=cnt+1. When cnt==NUM_REGS-1, -> IDLE and cnt<=0.
  - CLEAR lasts exactly NUM_REGS cycles; ready=0 throughout. clr_req is ignored while in CLEAR.
  - Reads during CLEAR return live array contents with no bypass.
- The clear counter is ADDR_W bits wide and wraps only through the terminal-state transition.

Decomposition:
- Package rf_pkg: FSM state enum (IDLE, CLEAR); clog2-safe ADDR_W helper function; DATA_W/NUM_REGS defaults as localparams.
- Sub-module rf_word #(DATA_W): one register with async active-low reset, write enable and sync clear. It is instantiated NUM_REGS times in a generate loop.
- Scoreboard, FSM and read muxes stay in the top level.

Test Plan:
- Write/read: reset, write 16'hBEEF to r3, then next cycle rd_sel0=3 -> rd_data0=BEEF. rd_sel1=5 -> 0000.
- Bypass: wr r2=16'h1234 with rd_sel0=2 in the same cycle -> rd_data0=1234 that cycle (BYPASS=1). With BYPASS=0 -> old value 0000, then 1234 on the next cycle.
- Scoreboard:
  - iss r4 -> rd_busy for sel 4 = 1 next cycle.
  - Write r4 -> rd_busy=0 in that cycle (bypass) and afterwards.
  - iss r4 again while busy, no write -> err=1 and stays 1.
- Flash clear:
  - Load r0..r7 with nonzero values, pulse clr_req -> ready=0 for exactly 8 cycles; r[k] reads 0 after cycle k.
  - wr_en during CLEAR is dropped.
  - ready returns to 1 on the 9th cycle.
- Reset mid-clear: assert rst=0 at cycle 3 of CLEAR -> ready=1, all regs 0 and busy 0 immediately. After release the FSM is IDLE.
- Param sweep: NUM_REGS=6, ZERO_REG0=1, NUM_RD=3.
  - wr r0=FFFF -> r0 reads 0.
  - wr_sel=7 -> err=1 and no register changes.
  - All three read ports return independent correct values.
